trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Exception/interrupt arbiter in the MEM stage, directly upstream of the CSR file.
- Each cycle it inspects the MEM-stage instruction's exception flags and the pending external/timer interrupt lines, gated by mstatus/mie.
- It issues a one-cycle trap request (excepttype, instruction address) to the CSR file.
- In the same cycle it issues a pipeline flush and redirect PC (mtvec-based for traps, mepc for mret).

Parameters:
- SYNC_STAGES, 2, synchronizer depth on ext_irq_i (minimum 2).
- VECTORED_EN, 1, 1 = honour mtvec.MODE=1 vectoring for interrupts; 0 = always direct.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_valid_i  in  1  MEM-stage instruction is valid (not a bubble)
- mem_inst_addr_i  in  32  PC of MEM-stage instruction
- mem_ecall_i  in  1  MEM instruction is ecall
- mem_illegal_i  in  1  MEM instruction is illegal
- mem_mret_i  in  1  MEM instruction is mret
- stall_i  in  1  pipeline stalled this cycle
- ext_irq_i  in  1  asynchronous external interrupt request, level
- timer_irq_i  in  1  synchronous timer interrupt request, level
- mstatus_i  in  32  from CSR file (bit 3 = MIE)
- mie_i  in  32  from CSR file (bit 11 = MEIE, bit 7 = MTIE)
- mtvec_i  in  32  from CSR file ([31:2] base, [1:0] mode)
- mepc_i  in  32  from CSR file
- excepttype_o  out  32  trap code to CSR file; 0 = none
- current_inst_addr_o  out  32  address to CSR file
- flush_o  out  1  flush all stages
- new_pc_o  out  32  redirect target, valid while flush_o=1
- busy_o  out  1  high in TRAP and HOLD

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; all outputs 0; synchronizer flops 0. Applies mid-TRAP/HOLD; no partial pulse survives.
- ext sync: ext_irq_i passes through SYNC_STAGES flops → ext_p. timer_p = timer_irq_i (no sync).
- Eligible (IDLE only, evaluated in decision cycle N): requires mem_valid_i=1 and stall_i=0. Otherwise no decision.
- Priority, highest first:
  - illegal → 0x00000002
  - ecall → 0x0000000B
  - mret → 0x0000000A
  - ext irq (ext_p & mie_i[11] & mstatus_i[3]) → 0x8000000B
  - timer irq (timer_p & mie_i[7] & mstatus_i[3]) → 0x80000007
- Synchronous causes are never masked by MIE.
- Latency: decision in cycle N → outputs registered, valid for exactly cycle N+1 (state TRAP). CSR file commits at end of N+1.
- TRAP cycle outputs:
  - excepttype_o = code
  - current_inst_addr_o = mem_inst_addr_i sampled at N
  - flush_o = 1
  - new_pc_o:
    - mret: mepc_i sampled at N
    - exceptions: {mtvec_i[31:2],2'b00}
    - interrupts with VECTORED_EN=1 and mtvec_i[1:0]=01: base + 4*code[3:0] (32-bit wrap)
    - mtvec mode 1x: treated as direct
- FSM: IDLE →(decision) TRAP → HOLD → IDLE.
  - HOLD lasts one cycle with all outputs 0 except busy_o. It lets updated mstatus reach mstatus_i, preventing re-entry on a stale MIE.
  - Flags presented during TRAP/HOLD are ignored (not queued).
- Outside TRAP, excepttype_o=0, flush_o=0, new_pc_o=0, current_inst_addr_o=0.
- Interrupt lines are level and not latched. A request deasserted before an eligible IDLE cycle is lost.
- Several flags set on one instruction: only the highest-priority one is reported.

Test Plan:
- mtvec_i=0x100, ecall at addr 0x80, mem_valid=1 → next cycle excepttype_o=0x0000000B, current_inst_addr_o=0x80, flush_o=1, new_pc_o=0x100; following cycle all 0, busy_o=1; then IDLE.
- mtvec_i=0x101, mstatus_i=0x8, mie_i=0x80, timer_irq_i=1, addr 0x200 → excepttype_o=0x80000007, current_inst_addr_o=0x200, new_pc_o=0x11C.
- mie_i=0x880, mstatus_i=0x8, ext_irq_i and timer_irq_i both high ≥SYNC_STAGES+1 cycles → excepttype_o=0x8000000B, new_pc_o=0x12C (vectored); with mstatus_i=0 → no flush ever.
- mret with mepc_i=0x84 → excepttype_o=0x0000000A, new_pc_o=0x84. Illegal+ecall simultaneously → 0x00000002, new_pc_o=0x100 (even if vectored).
- ecall with stall_i=1 for 3 cycles → no output; on first stall_i=0 cycle → pulse next cycle. ecall presented during HOLD → ignored.
- rst=1 during TRAP cycle → next cycle flush_o=0, excepttype_o=0, busy_o=0; ext_irq_i high at reset release → taken no earlier than SYNC_STAGES+1 cycles later.

Source files
------------

// File: rtl/trap_ctrl.sv
// MEM-stage trap arbiter: picks the highest-priority exception/interrupt, emits a
// one-cycle trap request plus flush/redirect to the CSR file, then holds one cycle.
module trap_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_inst_addr_i,
  input  logic        mem_ecall_i,
  input  logic        mem_illegal_i,
  input  logic        mem_mret_i,
  input  logic        stall_i,
  input  logic        ext_irq_i,
  input  logic        timer_irq_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  localparam logic [31:0] CODE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] CODE_ECALL   = 32'h0000_000B;
  localparam logic [31:0] CODE_MRET    = 32'h0000_000A;
  localparam logic [31:0] CODE_EXT     = 32'h8000_000B;
  localparam logic [31:0] CODE_TIMER   = 32'h8000_0007;

  typedef enum logic [1:0] {IDLE = 2'd0, TRAP = 2'd1, HOLD = 2'd2} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [31:0]            excepttype_q;
  logic [31:0]            inst_addr_q;
  logic                   flush_q;
  logic [31:0]            new_pc_q;
  logic                   busy_q;

  logic        ext_p;
  logic        timer_p;
  logic [31:0] cause_d;
  logic [31:0] new_pc_d;
  logic        take_d;
  logic        unused_csr_bits;

  // Redirect target: mepc for mret, vectored base+4*cause for interrupts in mode 01.
  function automatic logic [31:0] trap_target(input logic [31:0] cause,
                                              input logic [31:0] mtvec,
                                              input logic [31:0] mepc);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (cause == CODE_MRET) return mepc;
    if (cause[31] && VECTORED_EN && (mtvec[1:0] == 2'b01))
      return base + {26'd0, cause[3:0], 2'b00};
    return base;
  endfunction

  assign ext_p   = sync_q[SYNC_STAGES-1];
  assign timer_p = timer_irq_i;

  assign unused_csr_bits = ^{mstatus_i[31:4], mstatus_i[2:0],
                             mie_i[31:12], mie_i[10:8], mie_i[6:0]};

  always_comb begin
    cause_d = 32'd0;
    if (mem_illegal_i)                           cause_d = CODE_ILLEGAL;
    else if (mem_ecall_i)                        cause_d = CODE_ECALL;
    else if (mem_mret_i)                         cause_d = CODE_MRET;
    else if (ext_p && mie_i[11] && mstatus_i[3]) cause_d = CODE_EXT;
    else if (timer_p && mie_i[7] && mstatus_i[3]) cause_d = CODE_TIMER;
  end

  assign new_pc_d = trap_target(cause_d, mtvec_i, mepc_i);
  assign take_d   = (state_q == IDLE) && mem_valid_i && !stall_i && (cause_d != 32'd0);

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq_i};
  end

  // Outputs are registered: only the TRAP cycle carries a request, HOLD keeps busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      excepttype_q <= 32'd0;
      inst_addr_q  <= 32'd0;
      flush_q      <= 1'b0;
      new_pc_q     <= 32'd0;
      busy_q       <= 1'b0;
    end else begin
      excepttype_q <= 32'd0;
      inst_addr_q  <= 32'd0;
      flush_q      <= 1'b0;
      new_pc_q     <= 32'd0;
      busy_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take_d) begin
            state_q      <= TRAP;
            excepttype_q <= cause_d;
            inst_addr_q  <= mem_inst_addr_i;
            flush_q      <= 1'b1;
            new_pc_q     <= new_pc_d;
            busy_q       <= 1'b1;
          end
        end
        TRAP: begin
          state_q <= HOLD;
          busy_q  <= 1'b1;
        end
        HOLD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign excepttype_o        = excepttype_q;
  assign current_inst_addr_o = inst_addr_q;
  assign flush_o             = flush_q;
  assign new_pc_o            = new_pc_q;
  assign busy_o              = busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed scoreboard bench for trap_ctrl: expected outputs for the cycle after
// each clock edge are queued with the stimulus and popped after the edge.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_inst_addr_i;
  logic        mem_ecall_i, mem_illegal_i, mem_mret_i, stall_i;
  logic        ext_irq_i, timer_irq_i;
  logic [31:0] mstatus_i, mie_i, mtvec_i, mepc_i;
  logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o;
  logic        flush_o, busy_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] exc;
    logic [31:0] addr;
    logic [31:0] pc;
    logic        flush;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  trap_ctrl #(.SYNC_STAGES(2), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_inst_addr_i(mem_inst_addr_i),
    .mem_ecall_i(mem_ecall_i), .mem_illegal_i(mem_illegal_i), .mem_mret_i(mem_mret_i),
    .stall_i(stall_i), .ext_irq_i(ext_irq_i), .timer_irq_i(timer_irq_i),
    .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] exc, input logic [31:0] addr,
                      input logic [31:0] pc, input logic fl, input logic bz);
    exp_t e;
    e.tag = tag; e.exc = exc; e.addr = addr; e.pc = pc; e.flush = fl; e.busy = bz;
    sb.push_back(e);
  endtask

  task automatic push_idle(input string tag);
    push(tag, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic push_hold(input string tag);
    push(tag, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=exc:%h required=queued_entry", excepttype_o);
    end else begin
      e = sb.pop_front();
      assert ({excepttype_o, current_inst_addr_o, new_pc_o, flush_o, busy_o} ===
              {e.exc, e.addr, e.pc, e.flush, e.busy})
      else begin
        failures++;
        $error("FAIL %s observed exc=%h addr=%h pc=%h flush=%b busy=%b required exc=%h addr=%h pc=%h flush=%b busy=%b",
               e.tag, excepttype_o, current_inst_addr_o, new_pc_o, flush_o, busy_o,
               e.exc, e.addr, e.pc, e.flush, e.busy);
      end
    end
  endtask

  task automatic clr_inst();
    mem_valid_i = 1'b0; mem_inst_addr_i = 32'd0;
    mem_ecall_i = 1'b0; mem_illegal_i = 1'b0; mem_mret_i = 1'b0; stall_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_inst();
    ext_irq_i = 1'b0; timer_irq_i = 1'b0;
    mstatus_i = 32'd0; mie_i = 32'd0; mtvec_i = 32'd0; mepc_i = 32'd0;

    // Reset state
    push_idle("reset0"); tick();
    push_idle("reset1"); tick();
    rst = 1'b0;

    // ecall, direct mtvec
    mtvec_i = 32'h100; mem_valid_i = 1'b1; mem_inst_addr_i = 32'h80; mem_ecall_i = 1'b1;
    push("ecall_trap", 32'h0000_000B, 32'h80, 32'h100, 1'b1, 1'b1); tick();
    clr_inst();
    push_hold("ecall_hold"); tick();
    push_idle("ecall_idle"); tick();

    // timer interrupt, vectored
    mtvec_i = 32'h101; mstatus_i = 32'h8; mie_i = 32'h80; timer_irq_i = 1'b1;
    mem_valid_i = 1'b1; mem_inst_addr_i = 32'h200;
    push("timer_trap", 32'h8000_0007, 32'h200, 32'h11C, 1'b1, 1'b1); tick();
    clr_inst(); timer_irq_i = 1'b0;
    push_hold("timer_hold"); tick();
    push_idle("timer_idle"); tick();

    // ext + timer together: ext wins once synchronized
    mie_i = 32'h880; ext_irq_i = 1'b1; timer_irq_i = 1'b1;
    for (int i = 0; i < 3; i++) begin push_idle("irq_bubble"); tick(); end
    mem_valid_i = 1'b1; mem_inst_addr_i = 32'h300;
    push("ext_trap", 32'h8000_000B, 32'h300, 32'h12C, 1'b1, 1'b1); tick();
    mstatus_i = 32'd0;
    push_hold("ext_hold"); tick();
    for (int i = 0; i < 5; i++) begin push_idle("irq_masked"); tick(); end
    clr_inst(); ext_irq_i = 1'b0; timer_irq_i = 1'b0; mie_i = 32'd0;
    for (int i = 0; i < 3; i++) begin push_idle("drain"); tick(); end

    // mret
    mepc_i = 32'h84; mem_valid_i = 1'b1; mem_inst_addr_i = 32'h90; mem_mret_i = 1'b1;
    push("mret_trap", 32'h0000_000A, 32'h90, 32'h84, 1'b1, 1'b1); tick();
    clr_inst();
    push_hold("mret_hold"); tick();
    push_idle("mret_idle"); tick();

    // illegal + ecall: illegal wins, exceptions never vectored
    mem_valid_i = 1'b1; mem_inst_addr_i = 32'hA0; mem_illegal_i = 1'b1; mem_ecall_i = 1'b1;
    push("illegal_trap", 32'h0000_0002, 32'hA0, 32'h100, 1'b1, 1'b1); tick();
    clr_inst();
    push_hold("illegal_hold"); tick();
    push_idle("illegal_idle"); tick();

    // stalled ecall, then held-over ecall ignored in TRAP/HOLD
    mem_valid_i = 1'b1; mem_inst_addr_i = 32'hB0; mem_ecall_i = 1'b1; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin push_idle("ecall_stalled"); tick(); end
    stall_i = 1'b0;
    push("stall_release_trap", 32'h0000_000B, 32'hB0, 32'h100, 1'b1, 1'b1); tick();
    push_hold("ecall_in_trap_ignored"); tick();
    push_idle("ecall_in_hold_ignored"); tick();
    clr_inst();
    push_idle("post_hold_idle"); tick();

    // reset in the middle of TRAP, ext irq held across release
    mtvec_i = 32'h100; mem_valid_i = 1'b1; mem_inst_addr_i = 32'hC0; mem_ecall_i = 1'b1;
    push("pre_rst_trap", 32'h0000_000B, 32'hC0, 32'h100, 1'b1, 1'b1); tick();
    rst = 1'b1; mem_ecall_i = 1'b0; mem_inst_addr_i = 32'hD0;
    ext_irq_i = 1'b1; mstatus_i = 32'h8; mie_i = 32'h800;
    push_idle("rst_in_trap"); tick();
    rst = 1'b0;
    push_idle("sync_stage1"); tick();
    push_idle("sync_stage2"); tick();
    push("ext_after_rst", 32'h8000_000B, 32'hD0, 32'h100, 1'b1, 1'b1); tick();
    clr_inst(); ext_irq_i = 1'b0;
    push_hold("ext_after_rst_hold"); tick();
    push_idle("ext_after_rst_idle"); tick();

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
